// File: rtl/commit_trace_buffer.sv
// Commit-stream trace buffer: circular capture, PC-match trigger with post-count, oldest-first readout.
// Latency: a commit is readable one cycle after it is written; state changes are visible the next cycle.
// Backpressure: rd_* hold while rd_valid & !rd_ready; commits are never stalled and are dropped outside capture.
module commit_trace_buffer #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arm,
    input  logic            force_stop,
    input  logic            trig_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [AW:0]     post_count,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [31:0]     commit_instr,
    input  logic [XLEN-1:0] commit_result,
    input  logic            commit_we,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_pc,
    output logic [31:0]     rd_instr,
    output logic [XLEN-1:0] rd_result,
    output logic            rd_we,
    output logic            rd_last,
    output logic [1:0]      state,
    output logic [AW:0]     count,
    output logic            triggered
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] result;
        logic            we;
    } entry_t;

    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] MAX_POST = (AW+1)'(DEPTH - 1);

    entry_t          mem [DEPTH];
    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   remain_q, remain_d;
    logic            triggered_q, triggered_d;

    logic            capturing;
    logic            wr_en;
    logic            trig_hit;
    logic [AW:0]     post_clamp;
    entry_t          rd_ent;

    assign capturing  = (state_q == S_ARMED) || (state_q == S_POST);
    assign wr_en      = capturing && commit_valid;
    assign trig_hit   = (state_q == S_ARMED) && trig_en && commit_valid && (commit_pc == trig_pc);
    // Clamp keeps the trigger entry from being overwritten by its own post-trigger commits.
    assign post_clamp = (post_count > MAX_POST) ? MAX_POST : post_count;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remain_d    = remain_q;
        triggered_d = triggered_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d     = S_ARMED;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    triggered_d = 1'b0;
                end
            end
            S_ARMED, S_POST: begin
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (count_q != DEPTH_C) begin
                        count_d = count_q + (AW+1)'(1);
                    end
                end
                if (trig_hit) begin
                    triggered_d = 1'b1;
                    remain_d    = post_clamp[AW-1:0];
                    state_d     = (post_clamp == '0) ? S_DONE : S_POST;
                end
                if ((state_q == S_POST) && commit_valid) begin
                    remain_d = remain_q - AW'(1);
                    if (remain_q == AW'(1)) begin
                        state_d = S_DONE;
                    end
                end
                if (force_stop) begin
                    state_d = S_DONE;
                end
                // A full buffer truncates count to 0 here, which correctly lands on wr_ptr.
                if (state_d == S_DONE) begin
                    rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                end
            end
            S_DONE: begin
                if (arm) begin
                    state_d     = S_ARMED;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    triggered_d = 1'b0;
                end else if (count_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - (AW+1)'(1);
                    if (count_q == (AW+1)'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remain_q    <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remain_q    <= remain_d;
            triggered_q <= triggered_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= '{pc: commit_pc, instr: commit_instr, result: commit_result, we: commit_we};
        end
    end

    assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
    assign rd_ent    = rd_valid ? mem[rd_ptr_q] : '0;
    assign rd_pc     = rd_ent.pc;
    assign rd_instr  = rd_ent.instr;
    assign rd_result = rd_ent.result;
    assign rd_we     = rd_ent.we;
    assign rd_last   = rd_valid && (count_q == (AW+1)'(1));
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = triggered_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomized bench for commit_trace_buffer: queue-based window model feeds a scoreboard drained by a readout monitor.
module tb_commit_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            arm = 1'b0, force_stop = 1'b0, trig_en = 1'b0;
    logic [XLEN-1:0] trig_pc = '0;
    logic [AW:0]     post_count = '0;
    logic            commit_valid = 1'b0;
    logic [XLEN-1:0] commit_pc = '0;
    logic [31:0]     commit_instr = '0;
    logic [XLEN-1:0] commit_result = '0;
    logic            commit_we = 1'b0;
    logic            rd_valid, rd_ready = 1'b0;
    logic [XLEN-1:0] rd_pc, rd_result;
    logic [31:0]     rd_instr;
    logic            rd_we, rd_last, triggered;
    logic [1:0]      state;
    logic [AW:0]     count;

    commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .arm(arm), .force_stop(force_stop),
        .trig_en(trig_en), .trig_pc(trig_pc), .post_count(post_count),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
        .commit_result(commit_result), .commit_we(commit_we),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rd_result(rd_result), .rd_we(rd_we), .rd_last(rd_last),
        .state(state), .count(count), .triggered(triggered)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
        logic        we;
        logic        last;
    } ent_t;

    ent_t win[$];
    ent_t exp_q[$];
    int   capturing = 0;
    int   in_post = 0;
    int   rem = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks hold-while-stalled.
    logic        stalled = 1'b0;
    logic [96:0] held;
    always @(negedge clk) begin
        if (reset && rd_valid) begin
            if (stalled) chk("stall_hold", {rd_pc, rd_instr, rd_result, rd_we}, held);
            if (rd_ready) begin
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    ent_t e;
                    chk("rd_count", count, exp_q.size());
                    e = exp_q.pop_front();
                    chk("rd_pc", rd_pc, e.pc);
                    chk("rd_instr", rd_instr, e.instr);
                    chk("rd_result", rd_result, e.result);
                    chk("rd_we", rd_we, e.we);
                    chk("rd_last", rd_last, e.last);
                end
            end else begin
                stalled = 1'b1;
                held = {rd_pc, rd_instr, rd_result, rd_we};
            end
        end else begin
            stalled = 1'b0;
            if (reset) chk("rd_zero", {rd_pc, rd_instr, rd_result, rd_we, rd_last}, 0);
        end
    end

    task automatic close_window();
        for (int i = 0; i < win.size(); i++) begin
            ent_t e = win[i];
            e.last = (i == win.size() - 1);
            exp_q.push_back(e);
        end
        win.delete();
        capturing = 0;
        in_post = 0;
    endtask

    // One clock of stimulus; the reference model then applies the capture rules to it.
    task automatic step(input logic cv, input logic [31:0] pc, input logic fs, input logic am);
        ent_t e;
        commit_valid  = cv;
        commit_pc     = pc;
        commit_instr  = $urandom;
        commit_result = $urandom;
        commit_we     = 1'($urandom);
        force_stop    = fs;
        arm           = am;
        e = '{pc: pc, instr: commit_instr, result: commit_result, we: commit_we, last: 1'b0};
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        force_stop   = 1'b0;
        arm          = 1'b0;
        if (capturing != 0) begin
            if (cv) begin
                win.push_back(e);
                if (win.size() > DEPTH) void'(win.pop_front());
                if (in_post != 0) begin
                    rem--;
                    if (rem == 0) fs = 1'b1;
                end else if (trig_en && pc == trig_pc) begin
                    rem = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
                    if (rem == 0) fs = 1'b1;
                    else in_post = 1;
                end
            end
            if (fs) close_window();
        end else if (am) begin
            exp_q.delete();
            win.delete();
            capturing = 1;
            in_post = 0;
        end
    endtask

    task automatic drain(input int mode);
        int n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (state == 2'd0) break;
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'($urandom);
                default: rd_ready = (n % 3 == 0);
            endcase
            n++;
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b0;
        chk("drain_idle", state, 0);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic trig_run(input int post, input logic fs_at_trig);
        logic [31:0] pc;
        trig_en = 1'b1;
        trig_pc = 32'h40;
        post_count = (AW+1)'(post);
        step(0, 0, 0, 1);
        for (int i = 0; i < 64 && capturing != 0; i++) begin
            if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0);
            pc = 32'(4 * i);
            step(1, pc, (pc == 32'h40) && fs_at_trig, 0);
            if (pc == 32'h40) chk("state_after_trig", state, (post == 0 || fs_at_trig) ? 3 : 2);
        end
        chk("trig_flag", triggered, 1);
        chk("trig_done", state, 3);
        if (exp_q.size() > 0) begin
            chk("window_last_pc", exp_q[exp_q.size()-1].pc,
                fs_at_trig ? 32'h40 : 32'h40 + 4 * ((post > DEPTH - 1) ? DEPTH - 1 : post));
            if (post >= DEPTH - 1 && !fs_at_trig) chk("window_oldest_pc", exp_q[0].pc, 32'h40);
        end
    endtask

    initial begin
        #1;
        chk("reset_state", state, 0);
        chk("reset_count", count, 0);
        chk("reset_valid", rd_valid, 0);
        chk("reset_trig", triggered, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Commits in IDLE are dropped.
        step(1, 32'h100, 0, 0);
        chk("idle_ignore", count, 0);

        // Asynchronous reset in the middle of POST.
        trig_en = 1'b1; trig_pc = 32'h8; post_count = 5'd10;
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'(4 * i), 0, 0);
        chk("post_state", state, 2);
        chk("post_count", count, 5);
        #2;
        reset = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_count", count, 0);
        chk("async_valid", rd_valid, 0);
        chk("async_trig", triggered, 0);
        capturing = 0; in_post = 0; win.delete(); exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic capture, forced stop.
        trig_en = 1'b0;
        step(0, 0, 0, 1);
        chk("armed_state", state, 1);
        for (int i = 0; i < 5; i++) step(1, 32'(4 * i), 0, 0);
        step(0, 0, 1, 0);
        chk("fs_done", state, 3);
        chk("fs_count", count, 5);
        chk("fs_trig", triggered, 0);
        drain(0);

        // Wrap-around.
        step(0, 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) step(0, 0, 0, 0);
            step(1, 32'(4 * i), 0, 0);
        end
        step(0, 0, 1, 0);
        chk("wrap_count", count, 16);
        chk("wrap_oldest", exp_q[0].pc, 96);
        drain(1);

        trig_run(3, 1'b0);
        drain(2);
        trig_run(0, 1'b0);
        drain(1);
        trig_run(16, 1'b0);
        drain(2);
        trig_run(7, 1'b1);
        drain(0);

        // Forced stop with nothing captured.
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("empty_done", state, 3);
        chk("empty_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        chk("empty_idle", state, 0);

        // Re-arm in DONE with 3 entries left.
        trig_en = 1'b0;
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 32'(4 * i + 32'h200), 0, 0);
        step(0, 0, 1, 0);
        rd_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rd_ready = 1'b0;
        chk("partial_count", count, 3);
        step(0, 0, 0, 1);
        chk("rearm_state", state, 1);
        chk("rearm_count", count, 0);
        chk("rearm_valid", rd_valid, 0);
        step(0, 0, 1, 0);
        drain(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesisable retirement-trace capture block that sits beside the processor core and taps its commit stream (PC, instruction, ALU/writeback result, register-write enable).
- Records commits into a parametrised circular buffer.
- Freezes on a PC-match trigger after a programmable number of post-trigger commits, or on a forced stop.
- Streams the captured window, oldest entry first, over a valid/ready read port. This gives on-chip visibility of instruction flow.

Parameters:
XLEN, 32, width of PC and result fields
DEPTH, 16, number of trace entries; power of two, minimum 2
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
arm  input  1  single-cycle pulse to start a new capture
force_stop  input  1  ends capture immediately
trig_en  input  1  enables PC-match trigger
trig_pc  input  XLEN  trigger PC value
post_count  input  AW+1  commits recorded after the trigger entry; sampled at trigger
commit_valid  input  1  a commit occurs this cycle
commit_pc  input  XLEN  PC of committing instruction
commit_instr  input  32  committing instruction word
commit_result  input  XLEN  ALU/writeback value
commit_we  input  1  register-write enable of the commit
rd_valid  output  1  trace entry available on rd_*
rd_ready  input  1  consumer accepts entry
rd_pc  output  XLEN  entry PC
rd_instr  output  32  entry instruction
rd_result  output  XLEN  entry result
rd_we  output  1  entry write enable
rd_last  output  1  final entry of the window
state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
count  output  AW+1  valid entries held (0..DEPTH)
triggered  output  1  window was closed by the PC trigger

Behaviour:
Reset:
- While reset=0, asynchronously force state=IDLE, wr_ptr=0, rd_ptr=0, count=0, remaining=0, triggered=0.
- rd_valid=0, rd_last=0, all rd_* fields read 0. Buffer contents are don't-care.

IDLE:
- Commits are ignored.
- arm=1 -> ARMED next cycle; clears wr_ptr, count and triggered.

ARMED:
- Each commit_valid writes {pc, instr, result, we} at wr_ptr. wr_ptr increments mod DEPTH.
- count increments and saturates at DEPTH; once full, the oldest entry is overwritten.
- Trigger fires when trig_en & commit_valid & commit_pc==trig_pc. The trigger entry is written in the same cycle, triggered=1.
- After a trigger, remaining = min(post_count, DEPTH-1) so the trigger entry always survives.
- If remaining==0 -> DONE, else -> POST. The new state is visible one cycle after the trigger commit.

POST:
- Each commit is written as in ARMED and decrements remaining. The commit that takes remaining to 0 is written, then -> DONE.
- Further trigger matches are ignored.

force_stop:
- force_stop=1 in ARMED or POST -> DONE next cycle. A commit in the same cycle is still written. triggered is unchanged.
- force_stop wins over a same-cycle trigger: triggered is still set by the trigger commit.

arm:
- arm is ignored in ARMED and POST.
- arm in DONE aborts the readout and restarts as from IDLE.

Entering DONE:
- rd_ptr = (wr_ptr_next - count_next) mod DEPTH, i.e. the oldest entry.
- If count==0 -> IDLE next cycle and rd_valid is never asserted.

DONE:
- rd_valid=1 and rd_* show mem[rd_ptr] combinationally.
- A transfer occurs on rd_valid & rd_ready. On each transfer rd_ptr increments mod DEPTH and count decrements.
- rd_last=1 when count==1. The transfer with rd_last=1 -> IDLE next cycle.
- rd_* must stay stable while rd_valid & !rd_ready.
- When rd_valid=0, rd_* read 0.

Timing and arithmetic:
- Pointer arithmetic wraps modulo DEPTH. count never exceeds DEPTH and never underflows.
- Write-to-readable latency is one cycle. No commit is written outside ARMED/POST.

Test Plan:
- Reset and basic capture:
  - Assert reset=0 mid-POST with 5 entries held -> state=0, count=0, rd_valid=0 immediately, without waiting for a clock edge.
  - Then arm with trig_en=0, 5 commits at PC 0,4,..,16, then force_stop -> DONE.
  - Read out PCs 0,4,8,12,16 in order; rd_last only on 16; IDLE afterwards.
- Wrap-around, DEPTH=16:
  - 40 commits at PC 4*i, then force_stop -> count=16.
  - Readout yields PC 96..156; rd_last on 156.
- Trigger with post_count=3, trig_pc=0x40, commits at PC 0,4,8,...:
  - Capture stops after PC 0x4C; triggered=1; state=2 the cycle after the 0x40 commit.
  - Readout ends at 0x4C.
- post_count=0 and post_count=16:
  - post_count=0: trigger at 0x40 -> DONE the next cycle; last entry is 0x40.
  - post_count=16: clamped to 15; window is 0x40..0x7C with 0x40 as the oldest entry.
- Readout backpressure:
  - Toggle rd_ready 1,0,0,1,... -> rd_* stay stable while stalled, no entry is lost or duplicated, and count decrements only on accepted transfers.
- Edge cases:
  - force_stop with no commits -> DONE then IDLE, rd_valid never 1.
  - arm during DONE with 3 entries left -> ARMED, count=0, rd_valid=0 next cycle.
